// File: rtl/qspi_ram_responder_pkg.sv
// Shared definitions for the SPI/dual-SPI RAM responder: command codes, FSM states, timing constants.
package qspi_ram_responder_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_DUAL_READ = 8'h3B;

  localparam int unsigned DUMMY_CYCLES        = 8;
  localparam int unsigned MIN_SCK_HALF_PERIOD = 6;
  localparam int unsigned COUNT_WIDTH         = 5;

  typedef enum logic [2:0] {
    IDLE, COMMAND, ADDRESS, DUMMY, READ, WRITE, IGNORE
  } state_e;

  typedef enum logic [1:0] {
    OP_READ, OP_WRITE, OP_DUAL_READ
  } op_e;

  function automatic logic [3:0] laneMask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/qspi_ram_responder_pin_synchroniser.sv
// Two-flop synchronisers for csb/sck/io0 plus edge detection on the synchronised sck and csb.
module qspi_pin_synchroniser (
  input  logic clk,
  input  logic rst_n,
  input  logic csb,
  input  logic sck,
  input  logic io0,
  output logic sckRise,
  output logic sckFall,
  output logic csbActive,
  output logic csbStart,
  output logic csbEnd,
  output logic io0Sync
);

  logic [1:0] csbPipe;
  logic [1:0] sckPipe;
  logic [1:0] io0Pipe;
  logic       sckPrev;
  logic       csbPrev;

  // csb resets to the deselected level so reset release never looks like a select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csbPipe <= 2'b11;
      sckPipe <= 2'b00;
      io0Pipe <= 2'b00;
      sckPrev <= 1'b0;
      csbPrev <= 1'b1;
    end else begin
      csbPipe <= {csbPipe[0], csb};
      sckPipe <= {sckPipe[0], sck};
      io0Pipe <= {io0Pipe[0], io0};
      sckPrev <= sckPipe[1];
      csbPrev <= csbPipe[1];
    end
  end

  assign sckRise   = sckPipe[1] & ~sckPrev;
  assign sckFall   = ~sckPipe[1] & sckPrev;
  assign csbActive = ~csbPipe[1];
  assign csbStart  = ~csbPipe[1] & csbPrev;
  assign csbEnd    = csbPipe[1] & ~csbPrev;
  assign io0Sync   = io0Pipe[1];

endmodule

// File: rtl/qspi_ram_responder.sv
// SPI RAM target serving byte reads/writes from a 32-bit word SRAM port; SCK is oversampled on clk.
// Define QSPI_RESPONDER_DUAL_READ_EN to add the 0x3B dual-output read command.
module qspi_ram_responder
  import qspi_ram_responder_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE      = 24,
  parameter int unsigned SRAM_ADDRESS_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         device_csb,
  input  logic                         device_sck,
  input  logic                         device_io0_read,
  output logic                         device_io0_write,
  output logic                         device_io0_we,
  input  logic                         device_io1_read,
  output logic                         device_io1_write,
  output logic                         device_io1_we,
  output logic                         sram_select,
  output logic                         sram_writeEnable,
  output logic [3:0]                   sram_writeMask,
  output logic [SRAM_ADDRESS_SIZE-1:0] sram_address,
  output logic [31:0]                  sram_dataWrite,
  input  logic [31:0]                  sram_dataRead,
  output logic                         busy
);

  logic sckRise, sckFall, csbActive, csbStart, csbEnd, io0Sync;

  qspi_pin_synchroniser u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .csb      (device_csb),
    .sck      (device_sck),
    .io0      (device_io0_read),
    .sckRise  (sckRise),
    .sckFall  (sckFall),
    .csbActive(csbActive),
    .csbStart (csbStart),
    .csbEnd   (csbEnd),
    .io0Sync  (io0Sync)
  );

  state_e                  state;
  op_e                     op;
  logic [COUNT_WIDTH-1:0]  bitCount;
  logic [7:0]              cmdShift;
  logic [ADDRESS_SIZE-1:0] address;
  logic [7:0]              shiftReg;
  logic                    loadPending;
  logic [1:0]              loadLane;
  logic                    io1Write;
  logic                    io1We;

  logic [7:0]              cmdNext;
  logic [7:0]              byteNext;
  logic [7:0]              laneByte;
  logic [ADDRESS_SIZE-1:0] addressShifted;
  logic [ADDRESS_SIZE-1:0] addressInc;
  logic [ADDRESS_SIZE-1:0] readAddr;
  logic [COUNT_WIDTH-1:0]  bitCountInc;
  logic                    addrLast, dummyLast, byteLast;
  logic                    issueRead, issueWrite;

  assign cmdNext        = {cmdShift[6:0], io0Sync};
  assign byteNext       = {shiftReg[6:0], io0Sync};
  assign laneByte       = sram_dataRead[{loadLane, 3'b000} +: 8];
  assign addressShifted = {address[ADDRESS_SIZE-2:0], io0Sync};
  assign addressInc     = address + ADDRESS_SIZE'(1);
  assign bitCountInc    = bitCount + COUNT_WIDTH'(1);
  assign addrLast       = bitCount == COUNT_WIDTH'(ADDRESS_SIZE - 1);
  assign dummyLast      = bitCount == COUNT_WIDTH'(DUMMY_CYCLES - 1);
  assign byteLast       = bitCount == ((op == OP_DUAL_READ) ? COUNT_WIDTH'(3) : COUNT_WIDTH'(7));

  // One SRAM access per byte boundary; a read always fetches the byte about to be shifted out
  always_comb begin
    issueRead  = 1'b0;
    issueWrite = 1'b0;
    readAddr   = address;
    if (sckRise && !csbEnd) begin
      case (state)
        ADDRESS: begin
          issueRead = addrLast && (op == OP_READ);
          readAddr  = addressShifted;
        end
        DUMMY: issueRead = dummyLast;
        READ: begin
          issueRead = byteLast;
          readAddr  = addressInc;
        end
        WRITE:   issueWrite = bitCount == COUNT_WIDTH'(7);
        default: ;
      endcase
    end
  end

`ifdef QSPI_RESPONDER_DUAL_READ_EN
  logic io0Write;
  logic io0We;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      op               <= OP_READ;
      bitCount         <= '0;
      cmdShift         <= '0;
      address          <= '0;
      shiftReg         <= '0;
      loadPending      <= 1'b0;
      loadLane         <= '0;
      io1Write         <= 1'b0;
      io1We            <= 1'b0;
      busy             <= 1'b0;
      sram_select      <= 1'b0;
      sram_writeEnable <= 1'b0;
      sram_writeMask   <= '0;
      sram_address     <= '0;
      sram_dataWrite   <= '0;
`ifdef QSPI_RESPONDER_DUAL_READ_EN
      io0Write         <= 1'b0;
      io0We            <= 1'b0;
`endif
    end else begin
      sram_select <= 1'b0;
      loadPending <= sram_select & ~sram_writeEnable;
      busy        <= csbActive;
      if (loadPending) shiftReg <= laneByte;

      if (issueRead) begin
        sram_select      <= 1'b1;
        sram_writeEnable <= 1'b0;
        sram_writeMask   <= '0;
        sram_address     <= readAddr[SRAM_ADDRESS_SIZE+1:2];
        loadLane         <= readAddr[1:0];
      end
      if (issueWrite) begin
        sram_select      <= 1'b1;
        sram_writeEnable <= 1'b1;
        sram_writeMask   <= laneMask(address[1:0]);
        sram_address     <= address[SRAM_ADDRESS_SIZE+1:2];
        sram_dataWrite   <= {4{byteNext}};
      end

      if (csbEnd) begin
        state    <= IDLE;
        bitCount <= '0;
        io1We    <= 1'b0;
        io1Write <= 1'b0;
`ifdef QSPI_RESPONDER_DUAL_READ_EN
        io0We    <= 1'b0;
        io0Write <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: if (csbStart) begin
            state    <= COMMAND;
            bitCount <= '0;
          end
          COMMAND: if (sckRise) begin
            cmdShift <= cmdNext;
            bitCount <= bitCountInc;
            if (bitCount == COUNT_WIDTH'(7)) begin
              bitCount <= '0;
              state    <= ADDRESS;
              case (cmdNext)
                CMD_READ:      op <= OP_READ;
                CMD_WRITE:     op <= OP_WRITE;
`ifdef QSPI_RESPONDER_DUAL_READ_EN
                CMD_DUAL_READ: op <= OP_DUAL_READ;
`endif
                default:       state <= IGNORE;
              endcase
            end
          end
          ADDRESS: if (sckRise) begin
            address  <= addressShifted;
            bitCount <= bitCountInc;
            if (addrLast) begin
              bitCount <= '0;
              case (op)
                OP_WRITE: state <= WRITE;
                OP_READ: begin
                  state <= READ;
                  io1We <= 1'b1;
                end
                default: state <= DUMMY;
              endcase
            end
          end
          DUMMY: if (sckRise) begin
            bitCount <= bitCountInc;
            if (dummyLast) begin
              bitCount <= '0;
              state    <= READ;
              io1We    <= 1'b1;
`ifdef QSPI_RESPONDER_DUAL_READ_EN
              io0We    <= 1'b1;
`endif
            end
          end
          READ: begin
            if (sckRise) begin
              bitCount <= bitCountInc;
              if (byteLast) begin
                bitCount <= '0;
                address  <= addressInc;
              end
            end
            if (sckFall) begin
`ifdef QSPI_RESPONDER_DUAL_READ_EN
              if (op == OP_DUAL_READ) begin
                io1Write <= shiftReg[7];
                io0Write <= shiftReg[6];
                shiftReg <= {shiftReg[5:0], 2'b00};
              end else
`endif
              begin
                io1Write <= shiftReg[7];
                shiftReg <= {shiftReg[6:0], 1'b0};
              end
            end
          end
          WRITE: if (sckRise) begin
            shiftReg <= byteNext;
            bitCount <= bitCountInc;
            if (bitCount == COUNT_WIDTH'(7)) begin
              bitCount <= '0;
              address  <= addressInc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign device_io1_write = io1Write;
  assign device_io1_we    = io1We;
`ifdef QSPI_RESPONDER_DUAL_READ_EN
  assign device_io0_write = io0Write;
  assign device_io0_we    = io0We;
`else
  assign device_io0_write = 1'b0;
  assign device_io0_we    = 1'b0;
`endif

  // io1 is never sampled and aliased address bits never reach the SRAM
  logic unusedBits;
  assign unusedBits = ^{device_io1_read, cmdShift[7], readAddr[ADDRESS_SIZE-1:SRAM_ADDRESS_SIZE+2]};

endmodule
